// File: rtl/unit_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : unit_issue_buffer
// Description : Responder end of the unit issue interface for a
//               variable-latency execution unit. Issued requests are buffered
//               in an in-order FIFO and launched one at a time into the
//               attached engine through a start/done handshake. Each result
//               is held on the writeback interface until it is acknowledged.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   new_request         : issue handshake, request accepted this cycle
//   issue_id/issue_data : ID and packed operand payload of the request
//   ready               : buffer has room (registered state only)
//   eng_start           : one-cycle engine launch pulse
//   eng_id / eng_op     : ID launched or executing / payload at launch
//   eng_done/eng_result : engine completion pulse and result
//   wb_done/wb_id/wb_rd : writeback result, held until wb_ack
//   wb_ack              : writeback accepted
//
// Optional feature macro
//   UNIT_ISSUE_BYPASS_EN : when defined, a request arriving in IDLE with an
//                          empty FIFO is launched in the same cycle, bypassing
//                          the FIFO.
//
// Revision    : 1.0  initial release
// ============================================================================
module unit_issue_buffer #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 3,
  parameter int OP_W  = 72,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_request,
  input  logic [ID_W-1:0] issue_id,
  input  logic [OP_W-1:0] issue_data,
  output logic            ready,
  output logic            eng_start,
  output logic [ID_W-1:0] eng_id,
  output logic [OP_W-1:0] eng_op,
  input  logic            eng_done,
  input  logic [XLEN-1:0] eng_result,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [XLEN-1:0] wb_rd,
  input  logic            wb_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ID_W + OP_W;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   wb_id_q,  wb_id_d;
  logic [XLEN-1:0]   wb_rd_q,  wb_rd_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [ID_W-1:0]   head_id;
  logic [OP_W-1:0]   head_op;
  logic              bypass_take;
  logic              push;
  logic              pop;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_id    = head[ENT_W-1:OP_W];
  assign head_op    = head[OP_W-1:0];

  // ready depends only on the registered occupancy.
  assign ready = (count_q != FULL_COUNT);

`ifdef UNIT_ISSUE_BYPASS_EN
  // Only taken when nothing is queued, so issue order is preserved.
  assign bypass_take = (state_q == ST_IDLE) && fifo_empty && new_request;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = new_request && ready && !bypass_take;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  assign wb_done = (state_q == ST_WB);
  assign wb_id   = wb_id_q;
  assign wb_rd   = wb_rd_q;

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: next state and engine-side outputs.
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    wb_id_d   = wb_id_q;
    wb_rd_d   = wb_rd_q;
    eng_start = 1'b0;
    eng_id    = cur_id_q;
    eng_op    = '0;
    case (state_q)
      ST_IDLE: begin
        eng_id = '0;
        if (pop) begin
          eng_start = 1'b1;
          eng_id    = head_id;
          eng_op    = head_op;
          cur_id_d  = head_id;
          state_d   = ST_BUSY;
        end else if (bypass_take) begin
          eng_start = 1'b1;
          eng_id    = issue_id;
          eng_op    = issue_data;
          cur_id_d  = issue_id;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (eng_done) begin
          wb_rd_d = eng_result;
          wb_id_d = cur_id_q;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_id_q <= '0;
      wb_id_q  <= '0;
      wb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_id_q <= cur_id_d;
      wb_id_q  <= wb_id_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  // Payload storage needs no reset: an entry is only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {issue_id, issue_data};
    end
  end

endmodule
`default_nettype wire
